// File: rtl/seq_arith_popcount.sv
`default_nettype none
// ============================================================================
// Module   : seq_arith_popcount
// Purpose  : Multi-cycle population count over one NBITS-wide word per
//            val/rdy transaction. The word is consumed CHUNK bits per cycle,
//            least-significant chunk first, so only a CHUNK-wide bit counter
//            and an OBITS-wide accumulator are needed regardless of NBITS.
//            in_mode selects counting ones (0) or zeros (1).
//
// Ports    : clk      - clock
//            reset    - asynchronous, active-high reset
//            in_val   - input word valid
//            in_rdy   - block can accept a word (IDLE only)
//            in_      - word to count (sampled on the input handshake)
//            in_mode  - 0 = count ones, 1 = count zeros (sampled likewise)
//            out_val  - result valid (DONE only)
//            out_rdy  - consumer accepts result
//            out      - count result; zero whenever out_val is low
//
// Latency  : accept edge E0, chunks counted at edges E1..E_NCHUNKS, out_val
//            high right after E_NCHUNKS. No overlap between transactions.
//
// Revision : 1.0 - initial release
// ============================================================================
module seq_arith_popcount #(
    parameter int NBITS = 32,
    parameter int CHUNK = 8,
    parameter int OBITS = $clog2(NBITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in_,
    input  logic             in_mode,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [OBITS-1:0] out
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_nchunks = NBITS / CHUNK;
    // Width of a single chunk's bit count (0..CHUNK inclusive).
    localparam int c_cbits   = $clog2(CHUNK + 1);
    // Chunk index width; a single-chunk word still needs a 1-bit index.
    localparam int c_ibits   = (c_nchunks > 1) ? $clog2(c_nchunks) : 1;
    localparam logic [c_ibits-1:0] c_last_idx = c_ibits'(c_nchunks - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    // r_word is shifted right by CHUNK after each counted chunk, so the chunk
    // currently being counted always sits in the low CHUNK bits. This keeps
    // the selection logic to a fixed slice instead of an NCHUNKS-way mux.
    logic [NBITS-1:0]   r_word;
    logic               r_mode;
    logic [c_ibits-1:0] r_idx;
    logic [OBITS-1:0]   r_acc;

    logic [CHUNK-1:0]   w_chunk;
    logic [c_cbits-1:0] w_chunk_cnt;
    logic               w_accept;
    logic               w_count;

    // ------------------------------------------------------------------------
    // Chunk counter
    // ------------------------------------------------------------------------
    // Counting zeros is counting ones of the inverted chunk.
    assign w_chunk = r_word[CHUNK-1:0] ^ {CHUNK{r_mode}};

    always_comb begin
        w_chunk_cnt = '0;
        for (int i = 0; i < CHUNK; i++) begin
            w_chunk_cnt = w_chunk_cnt + c_cbits'(w_chunk[i]);
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_rdy      = 1'b0;
        out_val     = 1'b0;
        out         = '0;
        w_accept    = 1'b0;
        w_count     = 1'b0;

        case (r_state)
            S_IDLE: begin
                in_rdy   = 1'b1;
                w_accept = in_val;
                if (in_val) begin
                    w_state_nxt = S_BUSY;
                end
            end

            S_BUSY: begin
                w_count = 1'b1;
                // The edge that counts the last chunk also leaves BUSY, so
                // the accumulator is complete on the first DONE cycle.
                if (r_idx == c_last_idx) begin
                    w_state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                out_val = 1'b1;
                out     = r_acc;
                if (out_rdy) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word <= '0;
            r_mode <= 1'b0;
            r_idx  <= '0;
            r_acc  <= '0;
        end else if (w_accept) begin
            r_word <= in_;
            r_mode <= in_mode;
            r_idx  <= '0;
            r_acc  <= '0;
        end else if (w_count) begin
            // Accumulator is OBITS wide and the total never exceeds NBITS,
            // so the zero-extended add cannot overflow.
            r_acc  <= r_acc + OBITS'(w_chunk_cnt);
            r_word <= r_word >> CHUNK;
            r_idx  <= r_idx + c_ibits'(1);
        end
    end

endmodule
`default_nettype wire
